// File: rtl/bpu.sv
// Direct-mapped branch prediction unit: tagged entries with a target and a saturating
// direction counter; combinational lookup, single-edge training. Optional stats via `BPU_STATS_EN.
module bpu #(
  parameter int PC_WIDTH      = 8,
  parameter int NUM_ENTRIES   = 16,
  parameter int COUNTER_WIDTH = 2,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   i_pc,
  output logic                  o_hit,
  output logic                  o_taken,
  output logic [PC_WIDTH-1:0]   o_next_pc,
  input  logic                  i_clear,
  input  logic                  i_update_valid,
  input  logic [PC_WIDTH-1:0]   i_update_pc,
  input  logic                  i_update_taken,
  input  logic [PC_WIDTH-1:0]   i_update_target,
`ifdef BPU_STATS_EN
  input  logic                  i_update_predicted,
  output logic [STAT_WIDTH-1:0] o_update_count,
  output logic [STAT_WIDTH-1:0] o_mispredict_count
`else
  input  logic                  i_update_predicted
`endif
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W;
  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CTR_WNT = CTR_MAX >> 1;
  localparam logic [COUNTER_WIDTH-1:0] CTR_WT  = ~CTR_WNT;

  logic                     valid_q  [NUM_ENTRIES];
  logic                     valid_d  [NUM_ENTRIES];
  logic [TAG_W-1:0]         tag_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]         tag_d    [NUM_ENTRIES];
  logic [PC_WIDTH-1:0]      target_q [NUM_ENTRIES];
  logic [PC_WIDTH-1:0]      target_d [NUM_ENTRIES];
  logic [COUNTER_WIDTH-1:0] ctr_q    [NUM_ENTRIES];
  logic [COUNTER_WIDTH-1:0] ctr_d    [NUM_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = i_pc[IDX_W-1:0];
  assign lk_tag = i_pc[PC_WIDTH-1:IDX_W];
  assign up_idx = i_update_pc[IDX_W-1:0];
  assign up_tag = i_update_pc[PC_WIDTH-1:IDX_W];

  // Lookup reads only registered state, so a same-cycle update is never bypassed.
  always_comb begin
    o_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    o_taken   = o_hit && ctr_q[lk_idx][COUNTER_WIDTH-1];
    o_next_pc = o_taken ? target_q[lk_idx] : i_pc + PC_WIDTH'(1);
  end

  // Training has no handshake: an update strobe is consumed every cycle it is high.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (i_clear) begin
      for (int i = 0; i < NUM_ENTRIES; i++) valid_d[i] = 1'b0;
    end else if (i_update_valid) begin
      if (up_hit) begin
        if (i_update_taken) begin
          target_d[up_idx] = i_update_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_d[up_idx] = ctr_q[up_idx] + COUNTER_WIDTH'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_d[up_idx] = ctr_q[up_idx] - COUNTER_WIDTH'(1);
        end
      end else if (i_update_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = i_update_target;
        ctr_d[up_idx]    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [STAT_WIDTH-1:0] upd_cnt_q, upd_cnt_d;
  logic [STAT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  // Stats count every strobe, including ones dropped by a same-cycle clear.
  always_comb begin
    upd_cnt_d = upd_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (i_update_valid && (upd_cnt_q != '1)) upd_cnt_d = upd_cnt_q + STAT_WIDTH'(1);
    if (i_update_valid && (i_update_predicted != i_update_taken) && (mis_cnt_q != '1))
      mis_cnt_d = mis_cnt_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_update_count     = upd_cnt_q;
  assign o_mispredict_count = mis_cnt_q;
`else
  logic unused_predicted;
  assign unused_predicted = i_update_predicted;
`endif

endmodule
